// File: rtl/instr_prefetch_queue_if.sv
// Fetch-side memory bus, redirect/halt controls and decode-side handshake
// of the instruction prefetch queue.
interface instr_prefetch_queue_if #(
    parameter int AW = 10
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          halt;
    logic          id_valid;
    logic [31:0]   id_ir;
    logic [31:0]   id_npc;
    logic          id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_npc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, halt, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_npc,
        output imem_ack, imem_rdata, redirect, redirect_pc, halt, id_ready
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches words over a req/ack bus into a small
// FIFO of {ir, pc+1} entries, flushing on redirects and stopping on a sticky halt.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    instr_prefetch_queue_if.master    bus
);
    localparam int             PW      = $clog2(DEPTH);
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   drain_addr_q, drain_addr_d;
    logic            halted_q, halted_d;
    logic [PW:0]     count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     ir_mem  [DEPTH];
    logic [31:0]     npc_mem [DEPTH];

    logic            halt_eff;
    logic            push;
    logic            pop;
    logic            id_valid;
    logic [PW+1:0]   count_pop;

    assign id_valid = (count_q != '0);

    always_comb begin
        halt_eff     = halted_q | bus.halt;
        halted_d     = halt_eff;
        push         = (state_q == REQ) && bus.imem_ack && !bus.redirect;
        pop          = id_valid && bus.id_ready && !bus.redirect;
        count_pop    = {1'b0, count_q} + (PW+2)'(pop);
        state_d      = state_q;
        drain_addr_d = drain_addr_q;
        fetch_pc_d   = fetch_pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;

        // A redirect flushes the queue and wins over any push or pop this cycle
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end

        unique case (state_q)
            IDLE: begin
                if (!halt_eff && (bus.redirect || count_pop < {1'b0, DEPTH_C})) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.imem_ack) begin
                    state_d = (count_d < DEPTH_C && !halt_eff) ? REQ : IDLE;
                end else if (bus.redirect) begin
                    // Keep driving the old address until the memory answers
                    state_d      = DRAIN;
                    drain_addr_d = fetch_pc_q[AW-1:0];
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    state_d = halt_eff ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC[AW-1:0];
            halted_q     <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= bus.imem_rdata;
            npc_mem[wr_ptr_q] <= fetch_pc_q + 32'd1;
        end
    end

    assign bus.imem_req  = (state_q != IDLE);
    assign bus.imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q[AW-1:0];
    assign bus.id_valid  = id_valid;
    assign bus.id_ir     = id_valid ? ir_mem[rd_ptr_q]  : 32'd0;
    assign bus.id_npc    = id_valid ? npc_mem[rd_ptr_q] : 32'd0;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed and randomized bench for instr_prefetch_queue against a
// transaction-level model (outstanding request, queue of {ir, npc}).
module tb_instr_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          AW       = 10;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic clk1 = 1'b0;
    logic rst_n;

    instr_prefetch_queue_if #(.AW(AW)) bus ();

    instr_prefetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: is a request on the bus, is its data stale, which
    // address is still owed, the next fetch address, halt, and the queue.
    bit            m_req;
    bit            m_stale;
    logic [AW-1:0] m_old;
    logic [31:0]   m_pc;
    bit            m_halted;
    logic [63:0]   q[$];

    int lat;
    int wl;
    bit auto_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_bus_addr();
        return m_stale ? m_old : m_pc[AW-1:0];
    endfunction

    function automatic int next_lat();
        return (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    endfunction

    task automatic model_reset();
        m_req = 0; m_stale = 0; m_old = RESET_PC[AW-1:0];
        m_pc = RESET_PC; m_halted = 0; q.delete();
    endtask

    task automatic model_edge();
        bit pop;
        bit hf;
        pop = (q.size() != 0) && bus.id_ready;
        hf  = m_halted || bus.halt;
        if (bus.redirect) begin
            q.delete();
            if (m_req && !m_stale && !bus.imem_ack) begin
                m_stale = 1; m_old = m_pc[AW-1:0];
            end else if (!(m_req && m_stale && !bus.imem_ack)) begin
                m_stale = 0; m_req = !hf;
            end
            m_pc = bus.redirect_pc;
        end else if (m_req && m_stale) begin
            if (pop) void'(q.pop_front());
            if (bus.imem_ack) begin m_stale = 0; m_req = !hf; end
        end else if (m_req) begin
            if (bus.imem_ack) begin
                chk("no_push_when_full", (q.size() < DEPTH) || pop, 1'b1);
                if (pop) void'(q.pop_front());
                q.push_back({bus.imem_rdata, m_pc + 32'd1});
                m_pc  = m_pc + 32'd1;
                m_req = (q.size() < DEPTH) && !hf;
            end else if (pop) void'(q.pop_front());
        end else begin
            if (!hf && (q.size() + int'(pop)) < DEPTH) m_req = 1;
            if (pop) void'(q.pop_front());
        end
        m_halted = hf;
    endtask

    task automatic compare_all();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        chk("imem_req",  bus.imem_req,  m_req);
        chk("imem_addr", bus.imem_addr, m_bus_addr());
        chk("id_valid",  bus.id_valid,  q.size() != 0);
        chk("id_ir",     bus.id_ir,     head[63:32]);
        chk("id_npc",    bus.id_npc,    head[31:0]);
    endtask

    task automatic tick();
        if (auto_ack) begin
            if (m_req && wl == 0) begin
                bus.imem_ack = 1'b1;
                wl = next_lat();
            end else begin
                bus.imem_ack = 1'b0;
                if (m_req) wl--;
            end
            bus.imem_rdata = 32'hA000_0000 | 32'(m_bus_addr());
        end
        @(posedge clk1);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 0; bus.imem_rdata = 0; bus.redirect = 0;
        bus.redirect_pc = 0; bus.halt = 0; bus.id_ready = 0;
        #2;
        model_reset();
        wl = next_lat();
        compare_all();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] oa;
        bit seen;
        int acks;
        rst_n = 1'b1;
        auto_ack = 1;
        lat = 0;
        #1;

        // Zero-wait memory streams consecutive addresses
        do_reset();
        bus.id_ready = 1;
        tick(); chk("t1_addr0", bus.imem_addr, 0); chk("t1_req", bus.imem_req, 1);
        tick(); chk("t1_addr1", bus.imem_addr, 1);
        chk("t1_ir", bus.id_ir, 32'hA000_0000); chk("t1_npc", bus.id_npc, 1);
        tick(); chk("t1_addr2", bus.imem_addr, 2);
        tick(); chk("t1_addr3", bus.imem_addr, 3);

        // Full queue stops fetching, draining resumes at address 4
        do_reset();
        acks = 0;
        for (int i = 0; i < 30 && !(m_req == 0 && q.size() == DEPTH); i++) begin
            tick();
            if (bus.imem_ack) acks++;
        end
        chk("t2_acks", acks, 4); chk("t2_req_off", bus.imem_req, 0);
        bus.id_ready = 1;
        tick(); chk("t2_pop_npc", bus.id_npc, 2);
        for (int i = 0; i < 10 && !m_req; i++) tick();
        chk("t2_resume_addr", bus.imem_addr, 4); chk("t2_resume_req", bus.imem_req, 1);

        // Redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        bus.id_ready = 1;
        for (int i = 0; i < 40 && !(m_req && !m_stale && m_pc == 2 && wl >= 1); i++) tick();
        chk("t3_reach_addr2", m_req && m_pc == 2 && wl >= 1, 1);
        bus.redirect = 1; bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 0;
        chk("t3_hold_addr", bus.imem_addr, 2); chk("t3_flushed", bus.id_valid, 0);
        for (int i = 0; i < 10 && m_stale; i++) tick();
        chk("t3_target_addr", bus.imem_addr, 10'h40); chk("t3_target_req", bus.imem_req, 1);
        chk("t3_empty", bus.id_valid, 0);

        // Redirect coincident with ack and pop
        lat = 0;
        do_reset();
        bus.id_ready = 1;
        tick(); tick(); tick();
        bus.redirect = 1; bus.redirect_pc = 32'h10;
        tick();
        bus.redirect = 0;
        chk("t4_flushed", bus.id_valid, 0); chk("t4_addr", bus.imem_addr, 10'h10);
        tick();
        chk("t4_npc", bus.id_npc, 32'h11); chk("t4_ir", bus.id_ir, 32'hA000_0010);

        // Fetch address wraps from 0xFFFFFFFF
        do_reset();
        tick();
        bus.redirect = 1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        bus.redirect = 0;
        tick();
        chk("t6_npc_wrap", bus.id_npc, 0); chk("t6_valid", bus.id_valid, 1);
        chk("t6_addr_wrap", bus.imem_addr, 0); chk("t6_ir", bus.id_ir, 32'hA000_03FF);

        // Halt with a request outstanding
        lat = 3;
        do_reset();
        bus.id_ready = 1;
        for (int i = 0; i < 40 && !(m_req && !m_stale && m_pc == 3 && wl >= 1); i++) tick();
        oa = m_pc;
        bus.halt = 1;
        tick();
        bus.halt = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.id_valid && bus.id_npc == oa + 32'd1) seen = 1;
        end
        chk("t5_outstanding_queued", seen, 1);
        chk("t5_req_off", bus.imem_req, 0); chk("t5_drained", bus.id_valid, 0);
        bus.redirect = 1; bus.redirect_pc = 32'h80;
        tick();
        bus.redirect = 0;
        tick(); tick(); tick();
        chk("t5_redir_noreq", bus.imem_req, 0); chk("t5_redir_addr", bus.imem_addr, 10'h80);

        // Reset in the middle of a request; the late ack is ignored
        do_reset();
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t7_req_reset", bus.imem_req, 0);
        auto_ack = 0;
        @(negedge clk1);
        rst_n = 1'b1;
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("t7_stale_ignored", bus.id_valid, 0); chk("t7_req_up", bus.imem_req, 1);
        bus.imem_ack = 0;
        auto_ack = 1;
        wl = 3;

        // Randomized traffic
        lat = -1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                bus.id_ready    = ($urandom_range(0, 3) != 0);
                bus.redirect    = ($urandom_range(0, 19) == 0);
                bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                                              : 32'($urandom);
                bus.halt        = ($urandom_range(0, 249) == 0);
                tick();
            end
            bus.redirect = 0; bus.halt = 0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch unit sitting directly upstream of the decode stage. It fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, buffers them with their next-PC values in a small FIFO, and presents them to decode with a valid/ready handshake. It decouples variable-latency instruction memory from the pipeline and flushes on taken-branch redirects.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- AW, 10: instruction memory word-address width.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk1  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  word address; equals fetch_pc[AW-1:0].
- imem_ack  in  1  request completed this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch; flush and refetch.
- redirect_pc  in  32  target word address.
- halt  in  1  stop issuing fetches (sticky).
- id_valid  out  1  id_ir/id_npc hold a valid instruction.
- id_ir  out  32  instruction at FIFO head.
- id_npc  out  32  head instruction's address + 1.
- id_ready  in  1  decode consumes head when id_valid && id_ready.

## Operation

- Addresses are word addresses. fetch_pc is 32 bits and wraps from 0xFFFFFFFF to 0. Each entry stores {ir, pc+1}.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: imem_req=1, address held stable until ack.
  - DRAIN: a request is outstanding but its data is stale and will be dropped.
- IDLE→REQ when !halted and (count + pop) < DEPTH, where pop = id_valid && id_ready in the same cycle.
- REQ with ack:
  - push {imem_rdata, fetch_pc+1}; fetch_pc increments.
  - If space remains (count_next < DEPTH) and !halt, stay in REQ with the new address; otherwise go to IDLE.
- DRAIN with ack: discard imem_rdata and go to REQ at the redirect target (IDLE if halted).
- Redirect has priority over all other events in its cycle:
  - FIFO count cleared; any pop that cycle is ignored.
  - fetch_pc ← redirect_pc.
  - From REQ without ack: go to DRAIN. The request stays asserted at the old address until ack.
  - From REQ with ack in the same cycle: data discarded; go to REQ at redirect_pc.
  - From IDLE: go to REQ at redirect_pc.
  - From DRAIN: target updated, stay in DRAIN.
- halt:
  - Sets sticky halted; only reset clears it.
  - When halted, no new request is started. An outstanding request completes normally: it is pushed in REQ, or dropped in DRAIN.
  - The FIFO continues draining to decode.
  - A redirect while halted still flushes and updates fetch_pc but does not fetch.
- Simultaneous push and pop keeps count unchanged. Push when count==DEPTH cannot occur by construction; the verifier asserts this.
- id_valid = (count != 0). id_ir/id_npc come from the head entry and are 0 when empty.

## Timing

- Reset values (asynchronous):
  - imem_req=0, imem_addr=RESET_PC[AW-1:0].
  - id_valid=0, id_ir=0, id_npc=0.
  - count=0, state IDLE, halted=0, fetch_pc=RESET_PC.
- imem_req rises at the first clk1 edge after rst_n deasserts.
- ack is sampled at the clk1 edge. The pushed word appears with id_valid=1 on the following cycle, so ack-to-id_valid latency is 1 cycle.
- Zero-wait memory (ack in the same cycle as req) sustains one fetch per cycle while space remains.
- Redirect at edge N: id_valid=0 after N. The first target word is requested in cycle N+1, or after the stale ack when in DRAIN.
- Reset asserted mid-request: all state returns to reset values immediately; a later stale ack is ignored because state is IDLE.

## Test plan

- Reset then zero-wait memory returning word = 0xA000_0000|addr, id_ready=1:
  - imem_addr goes 0,1,2,3 on consecutive cycles.
  - id_ir=0xA0000000 with id_npc=1 appears one cycle after the first ack.
- id_ready=0, DEPTH=4:
  - Exactly 4 acks are accepted, then imem_req=0 with count=4.
  - Raising id_ready pops one entry per cycle and fetching resumes at address 4.
- Memory with 3-cycle ack latency, redirect to 0x40 while the request for address 2 is outstanding:
  - imem_addr holds 2 until ack; that data is discarded.
  - The next request is to 0x40; the FIFO is empty in between.
- Redirect to 0x10 coincident with an ack and with a pop:
  - The acked word is not queued and the pop has no effect.
  - The next id_npc seen is 0x11.
- halt asserted with a request outstanding:
  - The outstanding word is queued and no further imem_req is issued.
  - The FIFO drains to id_valid=0.
  - A later redirect is accepted, but imem_req stays 0.
- fetch_pc=0xFFFFFFFF:
  - The pushed id_npc is 0 and the next imem_addr is 0.
